// File: rtl/ps2_rx_fifo_pkg.sv
// Shared definitions for the PS/2 receive path.
// Frame layout constants, FSM states and parity helper.
package ps2_rx_fifo_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } ps2_state_t;

    // High when data plus parity bit hold an even number of ones.
    function automatic logic odd_par_err(
        input logic [7:0] d,
        input logic       p
    );
        return ~(^d ^ p);
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Scan-code read handshake between receiver and matrix scanner.
// The scanner pops with rden; q holds the last popped code.
interface ps2_rx_fifo_if;

    logic       rden;
    logic [7:0] q;
    logic       dsr;

    modport master (output rden, input q, input dsr);
    modport slave  (input rden, output q, output dsr);

endinterface

// File: rtl/ps2_rx_fifo_fifo.sv
// Scan-code FIFO with registered read port and status.
// A push at full succeeds only when a pop frees a slot.
module ps2_rx_fifo_fifo #(
    parameter int AW = 3
) (
    input  logic       clkk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] q,
    output logic       dsr,
    output logic       ovf
);

    localparam int DEPTH = 1 << AW;
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = cnt[AW];
    assign empty   = (cnt == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign cnt_nxt = cnt + CW'(do_push) - CW'(do_pop);

    // Storage array; contents need no reset.
    always_ff @(posedge clkk) begin
        if (do_push) mem[wp] <= din;
    end

    // Pointers, occupancy, read register and status flags.
    always_ff @(posedge clkk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            q   <= 8'h00;
            dsr <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) begin
                q  <= mem[rp];
                rp <= rp + 1'b1;
            end
            cnt <= cnt_nxt;
            dsr <= (cnt_nxt != '0);
            ovf <= push & full & ~do_pop;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with scan-code FIFO.
// Syncs and filters the bus, deframes, checks, buffers bytes.
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int FIFO_AW        = 3
) (
    input  logic          clkk,
    input  logic          reset,
    input  logic          ps2_clk,
    input  logic          ps2_dat,
    ps2_rx_fifo_if.slave  rx,
    output logic          err,
    output logic          ovf
);

    localparam int FLW = $clog2(FILTER_LEN) + 1;
    localparam logic [FLW-1:0] FLT_LAST = FLW'(FILTER_LEN - 1);
    localparam logic [11:0] TMO = 12'(TIMEOUT_CYCLES);

    logic           clk_s1, clk_s2;
    logic           dat_s1, dat_s2;
    logic           clk_f, clk_f_d;
    logic [FLW-1:0] flt_cnt;
    logic           fall;

    ps2_state_t     state;
    logic [2:0]     bitcnt;
    logic [7:0]     shreg;
    logic           perr;
    logic [11:0]    tmo;
    logic           push;
    logic [7:0]     push_data;

    // Two-flop synchronisers; the idle bus level is high.
    always_ff @(posedge clkk) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Clock filter: accept a new level after FILTER_LEN samples.
    always_ff @(posedge clkk) begin
        if (reset) begin
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            flt_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_f   <= clk_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // Frame FSM with mid-frame timeout; push and err are pulses.
    always_ff @(posedge clkk) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            shreg     <= 8'h00;
            perr      <= 1'b0;
            tmo       <= 12'd0;
            err       <= 1'b0;
            push      <= 1'b0;
            push_data <= 8'h00;
        end else begin
            err  <= 1'b0;
            push <= 1'b0;
            if (state == IDLE || fall) tmo <= 12'd0;
            else tmo <= tmo + 12'd1;
            if (fall) begin
                unique case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state  <= DATA;
                            bitcnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PAR;
                    end
                    PAR: begin
                        perr  <= odd_par_err(shreg, dat_s2);
                        state <= STOP;
                    end
                    STOP: begin
                        if (dat_s2 && !perr) begin
                            push      <= 1'b1;
                            push_data <= shreg;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE && tmo == TMO) begin
                state <= IDLE;
                err   <= 1'b1;
                tmo   <= 12'd0;
            end
        end
    end

    ps2_rx_fifo_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clkk  (clkk),
        .reset (reset),
        .push  (push),
        .din   (push_data),
        .pop   (rx.rden),
        .q     (rx.q),
        .dsr   (rx.dsr),
        .ovf   (ovf)
    );

endmodule
